// File: rtl/hazard_flush_ctrl.sv
// Pipeline run/stall/flush producer: resolves load-use, taken branch/jump and
// multi-cycle data-memory waits, with a saturating stall counter and sticky timeout.
module hazard_flush_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RT_i,
  input  logic [4:0]       IFID_RS_i,
  input  logic [4:0]       IFID_RT_i,
  input  logic             IFID_uses_rt_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             ctrl_flush_o,
  output logic             exmem_write_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             timeout_o
);

  localparam int unsigned WAIT_W = 16;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              timeout_q;
  logic              freeze;
  logic              load_use;
  logic              redirect;

  assign load_use = IDEX_MemRead_i & (IDEX_RT_i != 5'd0) &
                    ((IDEX_RT_i == IFID_RS_i) |
                     (IFID_uses_rt_i & (IDEX_RT_i == IFID_RT_i)));
  assign redirect = branch_taken_i | jump_i;

  // State, wait counter, stall counter and sticky timeout
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (!pc_write_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (wait_d == WAIT_W'(MAX_WAIT)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Next state and Mealy outputs; a freeze outranks any hazard and never flushes
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    freeze        = 1'b0;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    ctrl_flush_o  = 1'b0;
    exmem_write_o = 1'b1;

    case (state_q)
      RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_ack_i) begin
          freeze = 1'b1;
          if (wait_q < WAIT_W'(MAX_WAIT)) begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end else begin
          state_d = RUN;
          wait_d  = '0;
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase

    if (freeze) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      exmem_write_o = 1'b0;
    end else if (load_use) begin
      // Branch in ID is re-evaluated next cycle once the load has forwarded
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      ctrl_flush_o = 1'b1;
    end else if (redirect) begin
      ifid_flush_o = 1'b1;
    end

    if (!rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      exmem_write_o = 1'b0;
      ifid_flush_o  = 1'b1;
      ctrl_flush_o  = 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Scoreboard bench for hazard_flush_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_hazard_flush_ctrl;

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned MAX_WAIT = 8;

  // Output patterns {pc_write, ifid_write, ifid_flush, ctrl_flush, exmem_write}
  localparam logic [4:0] P_DEF   = 5'b11001;
  localparam logic [4:0] P_STALL = 5'b00011;
  localparam logic [4:0] P_FLUSH = 5'b11101;
  localparam logic [4:0] P_FRZ   = 5'b00000;
  localparam logic [4:0] P_RST   = 5'b00110;

  typedef struct packed {
    int          idx;
    logic [21:0] val;
  } exp_t;

  logic             clk_i;
  logic             rst_i;
  logic             IDEX_MemRead_i;
  logic [4:0]       IDEX_RT_i;
  logic [4:0]       IFID_RS_i;
  logic [4:0]       IFID_RT_i;
  logic             IFID_uses_rt_i;
  logic             branch_taken_i;
  logic             jump_i;
  logic             mem_req_i;
  logic             mem_ack_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             ctrl_flush_o;
  logic             exmem_write_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic             timeout_o;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_vec    = 0;

  hazard_flush_ctrl #(
    .CNT_W   (CNT_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .IDEX_MemRead_i(IDEX_MemRead_i),
    .IDEX_RT_i     (IDEX_RT_i),
    .IFID_RS_i     (IFID_RS_i),
    .IFID_RT_i     (IFID_RT_i),
    .IFID_uses_rt_i(IFID_uses_rt_i),
    .branch_taken_i(branch_taken_i),
    .jump_i        (jump_i),
    .mem_req_i     (mem_req_i),
    .mem_ack_i     (mem_ack_i),
    .pc_write_o    (pc_write_o),
    .ifid_write_o  (ifid_write_o),
    .ifid_flush_o  (ifid_flush_o),
    .ctrl_flush_o  (ctrl_flush_o),
    .exmem_write_o (exmem_write_o),
    .stall_cnt_o   (stall_cnt_o),
    .timeout_o     (timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Drive one cycle of inputs just after the rising edge and queue its expectation
  task automatic step(input logic rst, input logic mr, input logic [4:0] xrt,
                      input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                      input logic br, input logic j, input logic req, input logic ack,
                      input logic [4:0] pat, input int cnt, input logic to);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i          = rst;
    IDEX_MemRead_i = mr;
    IDEX_RT_i      = xrt;
    IFID_RS_i      = rs;
    IFID_RT_i      = rt;
    IFID_uses_rt_i = uses;
    branch_taken_i = br;
    jump_i         = j;
    mem_req_i      = req;
    mem_ack_i      = ack;
    n_vec++;
    e.idx = n_vec;
    e.val = {pat, 16'(cnt), to};
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t        e;
      logic [21:0] got;
      e   = exp_q.pop_front();
      got = {pc_write_o, ifid_write_o, ifid_flush_o, ctrl_flush_o, exmem_write_o,
             stall_cnt_o, timeout_o};
      n_checks++;
      if (got !== e.val) begin
        n_errors++;
        $display("FAIL vec%0d: got pc/ifw/iff/cf/exw=%b cnt=%0d to=%b, expected %b cnt=%0d to=%b",
                 e.idx, got[21:17], got[16:1], got[0], e.val[21:17], e.val[16:1], e.val[0]);
      end
    end
  end

  initial begin
    rst_i          = 1'b0;
    IDEX_MemRead_i = 1'b0;
    IDEX_RT_i      = '0;
    IFID_RS_i      = '0;
    IFID_RT_i      = '0;
    IFID_uses_rt_i = 1'b0;
    branch_taken_i = 1'b0;
    jump_i         = 1'b0;
    mem_req_i      = 1'b0;
    mem_ack_i      = 1'b0;

    //   rst mr  xrt    rs     rt    use br j  req ack  pattern cnt to
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, P_RST,   0, 0);  // 1 reset
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, P_DEF,   0, 0);  // 2 idle
    step(1, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0, 0, P_STALL, 0, 0);  // 3 load-use rs
    step(1, 0, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0, 0, P_DEF,   1, 0);  // 4 bubble done
    step(1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, P_DEF,   1, 0);  // 5 $zero filtered
    step(1, 1, 5'd5, 5'd3, 5'd5, 0, 0, 0, 0, 0, P_DEF,   1, 0);  // 6 rt not a source
    step(1, 1, 5'd5, 5'd3, 5'd5, 1, 0, 0, 0, 0, P_STALL, 1, 0);  // 7 rt is a source
    step(1, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0, 0, 0, P_STALL, 2, 0);  // 8 load-use beats branch
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, P_FLUSH, 3, 0);  // 9 branch re-evaluated
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, P_FLUSH, 3, 0);  // 10 jump
    step(1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0, 1, 1, P_STALL, 3, 0);  // 11 req+ack falls through
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, P_DEF,   4, 0);  // 12 req+ack no hazard
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, P_FRZ,   4, 0);  // 13 wait 1
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, P_FRZ,   5, 0);  // 14 wait 2
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, P_FRZ,   6, 0);  // 15 wait 3
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, P_FRZ,   7, 0);  // 16 wait 4
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1, P_FLUSH, 8, 0);  // 17 ack with jump
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, P_DEF,   8, 0);  // 18 back in RUN
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, P_FRZ,   8, 0);  // 19 wait 1
    step(1, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 1, 1, P_STALL, 9, 0);  // 20 ack with load-use
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, P_DEF,  10, 0);  // 21 RUN
    for (int i = 0; i < 8; i++) begin                             // 22-29 waits 1..8
      step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, P_FRZ, 10 + i, 0);
    end
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, P_FRZ,  18, 1);  // 30 timeout set
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, P_FRZ,  19, 1);  // 31 saturated wait
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, P_DEF,  20, 1);  // 32 late ack releases
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, P_DEF,  20, 1);  // 33 timeout sticky
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, P_FRZ,  20, 1);  // 34 enter wait
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, P_RST,   0, 0);  // 35 async reset mid-wait
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, P_DEF,   0, 0);  // 36 RUN after reset
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, P_FRZ,   0, 0);  // 37 wait 1
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, P_FRZ,   1, 0);  // 38 still waiting for ack
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, P_DEF,   2, 0);  // 39 ack
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, P_DEF,   2, 0);  // 40 RUN

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_i);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left in scoreboard, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Producer side of the pipeline flush/stall interface. It decides each cycle whether the pipeline runs, stalls or flushes.
- Drives the ID/EX control-zeroing flush consumed by the flush mux, the IF/ID flush and the PC/IF-ID/EX-MEM write enables.
- Resolves three hazards: load-use, taken branch/jump in ID, and multi-cycle data-memory wait.
- Keeps a stall-cycle counter and a sticky memory-timeout flag for debug.

Parameters:
CNT_W, 16, width of stall_cnt_o (saturating)
MAX_WAIT, 255, MEM_WAIT cycles before timeout_o sets (1..2^16-1)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
IDEX_MemRead_i  input  1  instruction in EX is a load
IDEX_RT_i  input  5  load destination register in EX
IFID_RS_i  input  5  rs of instruction in ID
IFID_RT_i  input  5  rt of instruction in ID
IFID_uses_rt_i  input  1  ID instruction reads rt as a source
branch_taken_i  input  1  branch resolved taken in ID
jump_i  input  1  jump decoded in ID
mem_req_i  input  1  MEM stage has an access in progress this cycle
mem_ack_i  input  1  memory completes the access this cycle
pc_write_o  output  1  PC update enable
ifid_write_o  output  1  IF/ID register write enable
ifid_flush_o  output  1  clear IF/ID to a NOP
ctrl_flush_o  output  1  1 = flush mux drives zero WB/EX/MEM controls into ID/EX
exmem_write_o  output  1  EX/MEM and MEM/WB write enable (0 = freeze)
stall_cnt_o  output  CNT_W  cycles with pc_write_o=0, saturating
timeout_o  output  1  sticky: MEM_WAIT lasted MAX_WAIT cycles

Behaviour:
- FSM states: RUN and MEM_WAIT. Registered state, wait counter (16b), stall_cnt, timeout. All outputs are combinational from state and inputs (Mealy), so hazards act in the same cycle.
- Reset (rst_i=0, async): state=RUN, wait=0, stall_cnt_o=0, timeout_o=0.
  - While rst_i=0, force pc_write_o=0, ifid_write_o=0, exmem_write_o=0, ifid_flush_o=1, ctrl_flush_o=1.
- Reset mid-MEM_WAIT: return to RUN immediately, counters cleared.
- Default (no hazard): pc_write_o=1, ifid_write_o=1, exmem_write_o=1, ifid_flush_o=0, ctrl_flush_o=0.
- load_use = IDEX_MemRead_i & (IDEX_RT_i!=0) & ((IDEX_RT_i==IFID_RS_i) | (IFID_uses_rt_i & IDEX_RT_i==IFID_RT_i)).
- RUN priority, highest first:
  1. mem_req_i & !mem_ack_i: freeze all.
     - pc_write_o=0, ifid_write_o=0, exmem_write_o=0; both flushes 0.
     - Next state MEM_WAIT, wait=1.
  2. load_use: pc_write_o=0, ifid_write_o=0, ctrl_flush_o=1, exmem_write_o=1.
     - Branch/jump ignored this cycle (ifid_flush_o=0); it is re-evaluated next cycle with correct operands.
     - Exactly one bubble, because the load leaves EX.
  3. branch_taken_i | jump_i: ifid_flush_o=1, pc_write_o=1, ifid_write_o=1, ctrl_flush_o=0.
- mem_req_i & mem_ack_i in the same RUN cycle: no freeze; fall through to rules 2-3.
- MEM_WAIT:
  - mem_ack_i=0: freeze as in rule 1; wait increments, saturating at MAX_WAIT. When wait reaches MAX_WAIT, timeout_o=1 (sticky until reset) and the FSM stays in MEM_WAIT.
  - mem_ack_i=1: release freeze this cycle, so the pipeline captures the data. Apply rules 2-3 to the current ID/EX inputs. Next state RUN, wait=0.
- stall_cnt_o increments on every clock edge where rst_i=1 and pc_write_o=0; it holds at all-ones.
- A freeze never asserts ctrl_flush_o or ifid_flush_o, so no instruction is lost.

Test Plan:
- Load-use: IDEX_MemRead_i=1, IDEX_RT_i=8, IFID_RS_i=8 for 1 cycle -> pc_write_o=0, ifid_write_o=0, ctrl_flush_o=1 that cycle; stall_cnt_o 0->1; next cycle (MemRead=0) all defaults.
- $zero and rt filter: IDEX_RT_i=0=IFID_RS_i -> no stall. IDEX_RT_i=5=IFID_RT_i with IFID_uses_rt_i=0 -> no stall; with IFID_uses_rt_i=1 -> stall.
- Branch vs load-use collision: load_use and branch_taken_i both 1 -> ifid_flush_o=0, ctrl_flush_o=1. Next cycle with branch_taken_i=1 only -> ifid_flush_o=1, pc_write_o=1.
- Memory wait: mem_req_i=1, ack after 4 cycles with jump_i=1 on the ack cycle:
  - 4 frozen cycles (exmem_write_o=0).
  - Ack cycle: exmem_write_o=1, ifid_flush_o=1.
  - stall_cnt_o=4, state back in RUN.
- Timeout: MAX_WAIT=8, mem_req_i=1, no ack -> timeout_o=1 after the 8th wait cycle. Ack later -> release, timeout_o stays 1 until rst_i pulses low.
- Async reset mid-wait: drop rst_i low between clock edges during MEM_WAIT -> outputs go to their reset values immediately. After release, RUN state, stall_cnt_o=0, default outputs.
